apb_master_arbiter: RTL and testbench

- Two-requester APB master that shares one APB bus between a bridge port (requester 0) and a debug/DMA port (requester 1).
- Sequences the IDLE/SETUP/ACCESS protocol and drives PSEL, PENABLE, PADDR, PWRITE and PWDATA.
- Drives DECODE4BIT to the APB slave multiplexer and takes back PREADY, PRDATA and PSLVERR from it.
- Uses round-robin arbitration and returns a one-cycle ack with read data and error to the winning requester.

---
 rtl/apb_master_arbiter.sv | 158 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master with registered outputs.
// Optional ACCESS-phase timeout: define APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DEC_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  write0,
  input  logic [31:0]           wdata0,
  output logic                  ack0,
  output logic [31:0]           rdata0,
  output logic                  err0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  write1,
  input  logic [31:0]           wdata1,
  output logic                  ack1,
  output logic [31:0]           rdata1,
  output logic                  err1,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            DECODE4BIT,
  input  logic                  PREADY,
  input  logic [31:0]           PRDATA,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [15:0] TO_LIMIT =
    16'(TIMEOUT_CYCLES - 1);

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   elig0;
  logic   elig1;
  logic   pick;
  logic   done;
  logic   fin_err;
  logic [31:0] fin_rdata;
  logic [ADDR_WIDTH-1:0] a_sel;

`ifdef APB_TIMEOUT_EN
  logic [15:0] cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^TO_LIMIT;
`endif

  // A requester being acked this cycle is masked so it cannot win again
  assign elig0 = req0 & ~ack0;
  assign elig1 = req1 & ~ack1;
  assign a_sel = pick ? addr1 : addr0;

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (elig0 & elig1):  pick = ~last_grant;
      (elig1 & ~elig0): pick = 1'b1;
      default:          pick = 1'b0;
    endcase
  end

  always_comb begin
    done      = PREADY;
    fin_rdata = PWRITE ? '0 : PRDATA;
    fin_err   = PSLVERR;
`ifdef APB_TIMEOUT_EN
    if (!PREADY && cnt == TO_LIMIT) begin
      done      = 1'b1;
      fin_rdata = '0;
      fin_err   = 1'b1;
    end
`endif
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      DECODE4BIT <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            owner      <= pick;
            last_grant <= pick;
            PSEL       <= 1'b1;
            PADDR      <= a_sel;
            PWRITE     <= pick ? write1 : write0;
            PWDATA     <= pick ? wdata1 : wdata0;
            DECODE4BIT <= a_sel[DEC_LSB +: 4];
            state      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ACCESS: begin
          if (done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= IDLE;
            if (owner) begin
              ack1   <= 1'b1;
              rdata1 <= fin_rdata;
              err1   <= fin_err;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= fin_rdata;
              err0   <= fin_err;
            end
          end
`ifdef APB_TIMEOUT_EN
          else begin
            cnt <= cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: vector table plus
// hand-written contention, reset and timeout sequences.
module tb_apb_master_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [31:0] A5  = 32'hA5A5_5A5A;
  localparam logic [31:0] BAD = 32'h0BAD_F00D;
  localparam logic [31:0] ONE = 32'h1111_2222;
  localparam logic [31:0] WD  = 32'h1234_5678;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;

  logic        PCLK;
  logic        PRESETn;
  logic        req0, write0, req1, write1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  DECODE4BIT;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_arbiter #(
    .ADDR_WIDTH(16),
    .DEC_LSB(12),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .addr0(addr0), .write0(write0),
    .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .err0(err0),
    .req1(req1), .addr1(addr1), .write1(write1),
    .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .err1(err1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA),
    .DECODE4BIT(DECODE4BIT),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic r0; logic [15:0] a0; logic w0; logic [31:0] d0;
    logic r1; logic [15:0] a1; logic w1; logic [31:0] d1;
    logic rdy; logic [31:0] prd; logic serr;
    logic esel; logic een; logic [15:0] eaddr; logic ewr;
    logic [31:0] ewd; logic [3:0] edec;
    logic eack0; logic [31:0] erd0; logic eerr0;
    logic eack1; logic [31:0] erd1; logic eerr1;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [127:0] act_all();
    return 128'({PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                 DECODE4BIT, ack0, rdata0, err0,
                 ack1, rdata1, err1});
  endfunction

  function automatic logic [127:0] exp_all(input vec_t v);
    return 128'({v.esel, v.een, v.eaddr, v.ewr, v.ewd,
                 v.edec, v.eack0, v.erd0, v.eerr0,
                 v.eack1, v.erd1, v.eerr1});
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; addr0 = '0; write0 = 1'b0; wdata0 = '0;
    req1 = 1'b0; addr1 = '0; write1 = 1'b0; wdata1 = '0;
    PREADY = 1'b1; PRDATA = '0; PSLVERR = 1'b0;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    req0 = v.r0; addr0 = v.a0; write0 = v.w0; wdata0 = v.d0;
    req1 = v.r1; addr1 = v.a1; write1 = v.w1; wdata1 = v.d1;
    PREADY = v.rdy; PRDATA = v.prd; PSLVERR = v.serr;
  endtask

  initial begin
    logic bad;

    // single read, then masked re-request during ack
    vecs[0]  = '{H,16'h2004,L,Z32, L,16'h0,L,Z32, H,A5,L,
                 H,L,16'h2004,L,Z32,4'h2, L,Z32,L, L,Z32,L};
    vecs[1]  = '{H,16'h2004,L,Z32, L,16'h0,L,Z32, H,A5,L,
                 H,H,16'h2004,L,Z32,4'h2, L,Z32,L, L,Z32,L};
    vecs[2]  = '{H,16'h2004,L,Z32, L,16'h0,L,Z32, H,A5,L,
                 L,L,16'h2004,L,Z32,4'h2, H,A5,L, L,Z32,L};
    vecs[3]  = '{H,16'h2004,L,Z32, L,16'h0,L,Z32, H,A5,L,
                 L,L,16'h2004,L,Z32,4'h2, L,A5,L, L,Z32,L};
    vecs[4]  = '{L,16'h2004,L,Z32, L,16'h0,L,Z32, H,A5,L,
                 L,L,16'h2004,L,Z32,4'h2, L,A5,L, L,Z32,L};
    // write with 3 wait states, request fields change after grant
    vecs[5]  = '{L,16'h0,L,Z32, H,16'h3010,H,WD, L,A5,L,
                 H,L,16'h3010,H,WD,4'h3, L,A5,L, L,Z32,L};
    vecs[6]  = '{L,16'h0,L,Z32, H,16'h3010,H,WD, L,A5,L,
                 H,H,16'h3010,H,WD,4'h3, L,A5,L, L,Z32,L};
    vecs[7]  = '{L,16'h0,L,Z32, H,16'h3010,H,WD, L,A5,L,
                 H,H,16'h3010,H,WD,4'h3, L,A5,L, L,Z32,L};
    vecs[8]  = '{L,16'h0,L,Z32, H,16'hFFFF,H,DB, L,A5,L,
                 H,H,16'h3010,H,WD,4'h3, L,A5,L, L,Z32,L};
    vecs[9]  = '{L,16'h0,L,Z32, H,16'hFFFF,H,DB, L,A5,L,
                 H,H,16'h3010,H,WD,4'h3, L,A5,L, L,Z32,L};
    vecs[10] = '{L,16'h0,L,Z32, H,16'hFFFF,H,DB, H,A5,L,
                 L,L,16'h3010,H,WD,4'h3, L,A5,L, H,Z32,L};
    vecs[11] = '{L,16'h0,L,Z32, L,16'hFFFF,H,DB, H,A5,L,
                 L,L,16'h3010,H,WD,4'h3, L,A5,L, L,Z32,L};
    // slave error, then a clean read clears err0
    vecs[12] = '{H,16'h5008,L,Z32, L,16'h0,L,Z32, H,BAD,H,
                 H,L,16'h5008,L,Z32,4'h5, L,A5,L, L,Z32,L};
    vecs[13] = '{H,16'h5008,L,Z32, L,16'h0,L,Z32, H,BAD,H,
                 H,H,16'h5008,L,Z32,4'h5, L,A5,L, L,Z32,L};
    vecs[14] = '{H,16'h5008,L,Z32, L,16'h0,L,Z32, H,BAD,H,
                 L,L,16'h5008,L,Z32,4'h5, H,BAD,H, L,Z32,L};
    vecs[15] = '{L,16'h5008,L,Z32, L,16'h0,L,Z32, H,BAD,H,
                 L,L,16'h5008,L,Z32,4'h5, L,BAD,H, L,Z32,L};
    vecs[16] = '{H,16'h5008,L,Z32, L,16'h0,L,Z32, H,ONE,L,
                 H,L,16'h5008,L,Z32,4'h5, L,BAD,H, L,Z32,L};
    vecs[17] = '{H,16'h5008,L,Z32, L,16'h0,L,Z32, H,ONE,L,
                 H,H,16'h5008,L,Z32,4'h5, L,BAD,H, L,Z32,L};
    vecs[18] = '{H,16'h5008,L,Z32, L,16'h0,L,Z32, H,ONE,L,
                 L,L,16'h5008,L,Z32,4'h5, H,ONE,L, L,Z32,L};
    vecs[19] = '{L,16'h5008,L,Z32, L,16'h0,L,Z32, H,ONE,L,
                 L,L,16'h5008,L,Z32,4'h5, L,ONE,L, L,Z32,L};

    clear_inputs();
    do_reset();
    chk("reset_state", act_all(), 128'h0);

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i]);
      @(negedge PCLK);
      chk($sformatf("vec%0d", i), act_all(), exp_all(vecs[i]));
    end

    // contention: both held from reset, zero-wait slave
    clear_inputs();
    req0 = 1'b1; addr0 = 16'h1000;
    req1 = 1'b1; addr1 = 16'h7000; write1 = 1'b1;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      logic        e_sel, e_a0, e_a1;
      logic [15:0] e_addr;
      @(negedge PCLK);
      e_sel  = (n % 3) != 0;
      e_a0   = (n == 3) || (n == 9);
      e_a1   = (n == 6) || (n == 12);
      e_addr = (((n - 1) / 3) % 2) != 0 ? 16'h7000 : 16'h1000;
      chk($sformatf("rr_cycle%0d", n),
          128'({PSEL, ack0, ack1, PADDR}),
          128'({e_sel, e_a0, e_a1, e_addr}));
    end

    // reset during a wait-stated ACCESS
    clear_inputs();
    do_reset();
    req0 = 1'b1; addr0 = 16'h4000; PREADY = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("pre_reset_access", 128'({PSEL, PENABLE}), 128'(2'b11));
    req1 = 1'b1; addr1 = 16'h6000;
    #2 PRESETn = 1'b0;
    #1 chk("async_reset_drop",
           128'({PSEL, PENABLE, ack0, ack1}), 128'(4'b0000));
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    @(negedge PCLK);
    chk("post_reset_grant",
        128'({PSEL, PENABLE, ack0, ack1, PADDR}),
        128'({4'b1000, 16'h4000}));

    // stuck slave
    clear_inputs();
    do_reset();
    req0 = 1'b1; addr0 = 16'h8000; PREADY = 1'b0; PRDATA = A5;
`ifdef APB_TIMEOUT_EN
    for (int n = 1; n <= 6; n++) begin
      logic e_sel, e_en, e_ack, e_err;
      @(negedge PCLK);
      e_sel = n <= 5;
      e_en  = (n >= 2) && (n <= 5);
      e_ack = n == 6;
      e_err = n == 6;
      chk($sformatf("timeout_cycle%0d", n),
          128'({PSEL, PENABLE, ack0, err0, rdata0}),
          128'({e_sel, e_en, e_ack, e_err, Z32}));
      if (n == 6) req0 = 1'b0;
    end
`else
    bad = 1'b0;
    for (int n = 1; n <= 110; n++) begin
      @(negedge PCLK);
      if (n >= 2 && !(PSEL && PENABLE && !ack0 && !ack1))
        bad = 1'b1;
    end
    chk("no_timeout_hold", 128'(bad), 128'(1'b0));
    PREADY = 1'b1;
    @(negedge PCLK);
    req0 = 1'b0;
    chk("late_ready_ack",
        128'({PSEL, PENABLE, ack0, err0, rdata0}),
        128'({3'b001, 1'b0, A5}));
`endif

    @(negedge PCLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
